// File: rtl/mips_core_pkg.sv
// Shared definitions for the MIPS core memory subsystem: AXI field widths,
// the fixed read IDs of the two caches and the arbiter grant encoding.
package mips_core_pkg;

  localparam int ARID_WIDTH = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [ARID_WIDTH-1:0] I_CACHE_ARID = 4'd0;
  localparam logic [ARID_WIDTH-1:0] D_CACHE_ARID = 4'd1;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } ArbGrant;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker. req_i[0] is the I side, req_i[1] the D side;
// a grant value of 0 selects I and 1 selects D. On a tie the side that did not
// win last time is chosen. Purely combinational so that the read and write
// arbiters can wrap it in their own state machines.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  // Pick the lone requester, or alternate away from the previous winner on a tie
  always_comb begin
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Read-channel arbiter between the instruction cache, the data cache and the
// single memory read port. One burst is outstanding at a time: the grant is
// taken in IDLE, the address is presented in ADDR, and the grant is held
// through DATA until the final beat. ARLEN counts beats directly (0 means 1).
module mem_read_arbiter
  import mips_core_pkg::*;
#(
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   i_ar_arvalid_i,
  output logic                   i_ar_arready_o,
  input  logic [ARID_WIDTH-1:0]  i_ar_arid_i,
  input  logic [ADDR_WIDTH-1:0]  i_ar_araddr_i,
  input  logic [COUNT_WIDTH-1:0] i_ar_arlen_i,
  output logic                   i_r_rvalid_o,
  input  logic                   i_r_rready_i,
  output logic [ARID_WIDTH-1:0]  i_r_rid_o,
  output logic [DATA_WIDTH-1:0]  i_r_rdata_o,

  input  logic                   d_ar_arvalid_i,
  output logic                   d_ar_arready_o,
  input  logic [ARID_WIDTH-1:0]  d_ar_arid_i,
  input  logic [ADDR_WIDTH-1:0]  d_ar_araddr_i,
  input  logic [COUNT_WIDTH-1:0] d_ar_arlen_i,
  output logic                   d_r_rvalid_o,
  input  logic                   d_r_rready_i,
  output logic [ARID_WIDTH-1:0]  d_r_rid_o,
  output logic [DATA_WIDTH-1:0]  d_r_rdata_o,

  output logic                   m_ar_arvalid_o,
  input  logic                   m_ar_arready_i,
  output logic [ARID_WIDTH-1:0]  m_ar_arid_o,
  output logic [ADDR_WIDTH-1:0]  m_ar_araddr_o,
  output logic [COUNT_WIDTH-1:0] m_ar_arlen_o,
  input  logic                   m_r_rvalid_i,
  output logic                   m_r_rready_o,
  input  logic [ARID_WIDTH-1:0]  m_r_rid_i,
  input  logic [DATA_WIDTH-1:0]  m_r_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } ArbState;

  ArbState                state_q;
  ArbGrant                grant_q;
  ArbGrant                lastGrant_q;
  logic [COUNT_WIDTH-1:0] beatsLeft_q;

  logic                   pickGrant;
  logic [COUNT_WIDTH-1:0] arLenSel;
  logic [COUNT_WIDTH-1:0] beatsLeft_d;
  logic                   grantD;
  logic                   inAddr;
  logic                   inData;
  logic                   rBeat;

  rr_arbiter2 u_rr (
    .req_i        ({d_ar_arvalid_i, i_ar_arvalid_i}),
    .last_grant_i (lastGrant_q == GRANT_D),
    .grant_o      (pickGrant)
  );

  assign grantD = (grant_q == GRANT_D);
  assign inAddr = (state_q == S_ADDR);
  assign inData = (state_q == S_DATA);

  // Steer the AR channel from the granted cache and route R beats back to it;
  // outside DATA any stray memory beats are accepted and dropped
  always_comb begin
    arLenSel       = grantD ? d_ar_arlen_i : i_ar_arlen_i;
    beatsLeft_d    = (arLenSel == '0) ? COUNT_WIDTH'(1) : arLenSel;

    m_ar_arvalid_o = inAddr;
    m_ar_arid_o    = grantD ? d_ar_arid_i   : i_ar_arid_i;
    m_ar_araddr_o  = grantD ? d_ar_araddr_i : i_ar_araddr_i;
    m_ar_arlen_o   = arLenSel;
    i_ar_arready_o = inAddr && !grantD && m_ar_arready_i;
    d_ar_arready_o = inAddr &&  grantD && m_ar_arready_i;

    i_r_rvalid_o   = inData && !grantD && m_r_rvalid_i;
    d_r_rvalid_o   = inData &&  grantD && m_r_rvalid_i;
    i_r_rid_o      = m_r_rid_i;
    d_r_rid_o      = m_r_rid_i;
    i_r_rdata_o    = m_r_rdata_i;
    d_r_rdata_o    = m_r_rdata_i;
    m_r_rready_o   = inData ? (grantD ? d_r_rready_i : i_r_rready_i) : 1'b1;

    rBeat          = m_r_rvalid_i && m_r_rready_o;
  end

  // Burst sequencing: grant on request, hand off the address, count beats home
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= GRANT_I;
      lastGrant_q <= GRANT_I;
      beatsLeft_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_ar_arvalid_i || d_ar_arvalid_i) begin
            grant_q <= pickGrant ? GRANT_D : GRANT_I;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_ar_arready_i) begin
            beatsLeft_q <= beatsLeft_d;
            lastGrant_q <= grant_q;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (rBeat) begin
            beatsLeft_q <= beatsLeft_q - COUNT_WIDTH'(1);
            if (beatsLeft_q == COUNT_WIDTH'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios with literal expectations,
// then randomized cache/memory traffic, all watched by a burst-level model.
module tb_mem_read_arbiter;
  import mips_core_pkg::*;

  localparam int CW = 5;

  logic clk;
  logic rst_n;
  logic i_ar_arvalid_i, i_ar_arready_o, i_r_rvalid_o, i_r_rready_i;
  logic d_ar_arvalid_i, d_ar_arready_o, d_r_rvalid_o, d_r_rready_i;
  logic m_ar_arvalid_o, m_ar_arready_i, m_r_rvalid_i, m_r_rready_o;
  logic [ARID_WIDTH-1:0] i_ar_arid_i, i_r_rid_o, d_ar_arid_i, d_r_rid_o, m_ar_arid_o, m_r_rid_i;
  logic [ADDR_WIDTH-1:0] i_ar_araddr_i, d_ar_araddr_i, m_ar_araddr_o;
  logic [DATA_WIDTH-1:0] i_r_rdata_o, d_r_rdata_o, m_r_rdata_i;
  logic [CW-1:0] i_ar_arlen_i, d_ar_arlen_i, m_ar_arlen_o;

  int errors = 0;
  int checks = 0;

  mem_read_arbiter #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ar_arvalid_i(i_ar_arvalid_i), .i_ar_arready_o(i_ar_arready_o), .i_ar_arid_i(i_ar_arid_i),
    .i_ar_araddr_i(i_ar_araddr_i), .i_ar_arlen_i(i_ar_arlen_i),
    .i_r_rvalid_o(i_r_rvalid_o), .i_r_rready_i(i_r_rready_i), .i_r_rid_o(i_r_rid_o), .i_r_rdata_o(i_r_rdata_o),
    .d_ar_arvalid_i(d_ar_arvalid_i), .d_ar_arready_o(d_ar_arready_o), .d_ar_arid_i(d_ar_arid_i),
    .d_ar_araddr_i(d_ar_araddr_i), .d_ar_arlen_i(d_ar_arlen_i),
    .d_r_rvalid_o(d_r_rvalid_o), .d_r_rready_i(d_r_rready_i), .d_r_rid_o(d_r_rid_o), .d_r_rdata_o(d_r_rdata_o),
    .m_ar_arvalid_o(m_ar_arvalid_o), .m_ar_arready_i(m_ar_arready_i), .m_ar_arid_o(m_ar_arid_o),
    .m_ar_araddr_o(m_ar_araddr_o), .m_ar_arlen_o(m_ar_arlen_o),
    .m_r_rvalid_i(m_r_rvalid_i), .m_r_rready_o(m_r_rready_o), .m_r_rid_i(m_r_rid_i), .m_r_rdata_i(m_r_rdata_i)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst-level reference: who owns the port, which phase, how many beats remain
  int  mOwner = 0;
  int  mPhase = 0;
  int  mLast = 0;
  int  mBeats = 0;
  bit  modelValid = 1'b0;

  // Compare every cycle against the model, then advance it from this cycle's inputs
  always @(negedge clk) begin : model
    logic expRr;
    logic [CW-1:0] len;
    if (modelValid) begin
      checkOutput("ar_ctrl", {m_ar_arvalid_o, i_ar_arready_o, d_ar_arready_o},
                  {mPhase == 1, mPhase == 1 && mOwner == 0 && m_ar_arready_i,
                   mPhase == 1 && mOwner == 1 && m_ar_arready_i});
      if (mPhase == 1)
        checkOutput("ar_payload", {m_ar_arid_o, m_ar_arlen_o, m_ar_araddr_o},
                    (mOwner == 1) ? {d_ar_arid_i, d_ar_arlen_i, d_ar_araddr_i}
                                  : {i_ar_arid_i, i_ar_arlen_i, i_ar_araddr_i});
      expRr = (mPhase == 2) ? ((mOwner == 1) ? d_r_rready_i : i_r_rready_i) : 1'b1;
      checkOutput("r_ctrl", {i_r_rvalid_o, d_r_rvalid_o, m_r_rready_o},
                  {mPhase == 2 && mOwner == 0 && m_r_rvalid_i,
                   mPhase == 2 && mOwner == 1 && m_r_rvalid_i, expRr});
      if (mPhase == 2 && m_r_rvalid_i)
        checkOutput("r_payload", (mOwner == 1) ? {d_r_rid_o, d_r_rdata_o} : {i_r_rid_o, i_r_rdata_o},
                    {m_r_rid_i, m_r_rdata_i});
    end
    expRr = (mPhase == 2) ? ((mOwner == 1) ? d_r_rready_i : i_r_rready_i) : 1'b1;
    if (!rst_n) begin
      mPhase = 0; mLast = 0; mBeats = 0; modelValid = 1'b1;
    end else if (mPhase == 0) begin
      if (i_ar_arvalid_i && d_ar_arvalid_i) begin mOwner = 1 - mLast; mPhase = 1; end
      else if (d_ar_arvalid_i) begin mOwner = 1; mPhase = 1; end
      else if (i_ar_arvalid_i) begin mOwner = 0; mPhase = 1; end
    end else if (mPhase == 1) begin
      if (m_ar_arready_i) begin
        len = (mOwner == 1) ? d_ar_arlen_i : i_ar_arlen_i;
        mBeats = (len == 0) ? 1 : int'(len);
        mLast = mOwner;
        mPhase = 2;
      end
    end else if (m_r_rvalid_i && expRr) begin
      mBeats--;
      if (mBeats == 0) mPhase = 0;
    end
  end

  // Stimulus agents: two caches and a memory with a beat backlog
  bit hsIAr, hsDAr, hsMAr, hsMR;
  logic [CW-1:0] capLen;
  logic [ARID_WIDTH-1:0] capId, memId;
  int memBeats = 0;
  logic [ARID_WIDTH-1:0] grantLog[$];

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic captureHandshakes();
    hsIAr = i_ar_arvalid_i && i_ar_arready_o;
    hsDAr = d_ar_arvalid_i && d_ar_arready_o;
    hsMAr = m_ar_arvalid_o && m_ar_arready_i;
    hsMR  = m_r_rvalid_i && m_r_rready_o;
    capLen = m_ar_arlen_o;
    capId  = m_ar_arid_o;
    if (hsMAr) grantLog.push_back(m_ar_arid_o);
  endtask

  task automatic applyStimulus(input int pReq, input int pArRdy, input int pRv, input int pRr);
    if (hsIAr) i_ar_arvalid_i = 1'b0;
    if (hsDAr) d_ar_arvalid_i = 1'b0;
    if (hsMAr) begin memBeats += (capLen == 0) ? 1 : int'(capLen); memId = capId; end
    if (hsMR) begin m_r_rvalid_i = 1'b0; if (memBeats > 0) memBeats--; end
    if (!i_ar_arvalid_i && chance(pReq)) begin
      i_ar_arvalid_i = 1'b1; i_ar_arid_i = I_CACHE_ARID;
      i_ar_araddr_i = $urandom; i_ar_arlen_i = CW'($urandom_range(16, 0));
    end
    if (!d_ar_arvalid_i && chance(pReq)) begin
      d_ar_arvalid_i = 1'b1; d_ar_arid_i = D_CACHE_ARID;
      d_ar_araddr_i = $urandom; d_ar_arlen_i = CW'($urandom_range(16, 0));
    end
    if (!m_r_rvalid_i && memBeats > 0 && chance(pRv)) begin
      m_r_rvalid_i = 1'b1; m_r_rdata_i = $urandom; m_r_rid_i = memId;
    end
    m_ar_arready_i = chance(pArRdy);
    i_r_rready_i = chance(pRr);
    d_r_rready_i = chance(pRr);
    hsIAr = 0; hsDAr = 0; hsMAr = 0; hsMR = 0;
  endtask

  task automatic stepCycle(input int pReq, input int pArRdy, input int pRv, input int pRr);
    @(posedge clk); #1;
    applyStimulus(pReq, pArRdy, pRv, pRr);
    @(negedge clk);
    captureHandshakes();
  endtask

  task automatic drainIdle();
    int n = 0;
    bit done;
    do begin
      stepCycle(0, 100, 100, 100);
      n++;
      done = !i_ar_arvalid_i && !d_ar_arvalid_i && memBeats == 0 && !m_r_rvalid_i && !m_ar_arvalid_o;
    end while (!done && n < 200);
    checkOutput("drain_idle", done, 1'b1);
  endtask

  initial begin
    logic [ARID_WIDTH-1:0] got;
    int iBeats;
    rst_n = 1'b0;
    i_ar_arvalid_i = 0; i_ar_arid_i = I_CACHE_ARID; i_ar_araddr_i = 0; i_ar_arlen_i = 0; i_r_rready_i = 1;
    d_ar_arvalid_i = 0; d_ar_arid_i = D_CACHE_ARID; d_ar_araddr_i = 0; d_ar_arlen_i = 0; d_r_rready_i = 1;
    m_ar_arready_i = 0; m_r_rvalid_i = 0; m_r_rid_i = 0; m_r_rdata_i = 0;
    hsIAr = 0; hsDAr = 0; hsMAr = 0; hsMR = 0; capLen = 0; capId = 0; memId = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    checkOutput("reset_ar", {m_ar_arvalid_o, i_ar_arready_o, d_ar_arready_o}, 3'b000);
    checkOutput("reset_r", {i_r_rvalid_o, d_r_rvalid_o, m_r_rready_o}, 3'b001);

    // Simultaneous requests straight after reset: D wins, I follows two cycles after D's last beat
    @(posedge clk); #1;
    i_ar_arvalid_i = 1; i_ar_araddr_i = 32'h200; i_ar_arlen_i = 5'd4;
    d_ar_arvalid_i = 1; d_ar_araddr_i = 32'h300; d_ar_arlen_i = 5'd4;
    @(negedge clk);
    checkOutput("tie_idle_arvalid", m_ar_arvalid_o, 1'b0);
    @(posedge clk); #1;
    m_ar_arready_i = 1;
    @(negedge clk);
    checkOutput("tie_first_d", {m_ar_arvalid_o, m_ar_arid_o, m_ar_araddr_o}, {1'b1, 4'd1, 32'h300});
    checkOutput("tie_arready", {i_ar_arready_o, d_ar_arready_o}, 2'b01);
    @(posedge clk); #1;
    d_ar_arvalid_i = 0; m_ar_arready_i = 0; m_r_rid_i = D_CACHE_ARID;
    for (int b = 0; b < 4; b++) begin
      m_r_rvalid_i = 1; m_r_rdata_i = 32'hD000_0000 + 32'(b);
      @(negedge clk);
      checkOutput("tie_d_beat", {i_r_rvalid_o, d_r_rvalid_o, d_r_rdata_o}, {2'b01, 32'hD000_0000 + 32'(b)});
      @(posedge clk); #1;
    end
    m_r_rvalid_i = 0;
    @(negedge clk);
    checkOutput("tie_gap_k1", m_ar_arvalid_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tie_i_at_k2", {m_ar_arvalid_o, m_ar_arid_o, m_ar_araddr_o}, {1'b1, 4'd0, 32'h200});
    captureHandshakes();
    drainIdle();

    // I-cache alone with two-cycle bubbles between beats
    @(posedge clk); #1;
    i_ar_arvalid_i = 1; i_ar_araddr_i = 32'h100; i_ar_arlen_i = 5'd4; m_ar_arready_i = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ionly_ar", {m_ar_arvalid_o, i_ar_arready_o, d_ar_arready_o, m_ar_araddr_o}, {3'b110, 32'h100});
    @(posedge clk); #1;
    i_ar_arvalid_i = 0; m_ar_arready_i = 0; m_r_rid_i = I_CACHE_ARID;
    iBeats = 0;
    for (int b = 0; b < 4; b++) begin
      m_r_rvalid_i = 1; i_r_rready_i = 1; m_r_rdata_i = 32'hA000 + 32'(b);
      @(negedge clk);
      if (i_r_rvalid_o) iBeats++;
      checkOutput("ionly_beat", {i_r_rvalid_o, d_r_rvalid_o, i_r_rdata_o}, {2'b10, 32'hA000 + 32'(b)});
      @(posedge clk); #1;
      if (b < 3) begin
        repeat (2) begin
          m_r_rvalid_i = 0; i_r_rready_i = 0;
          @(negedge clk);
          if (i_r_rvalid_o) iBeats++;
          checkOutput("bubble_grant_held", {i_r_rvalid_o, m_r_rready_o}, 2'b00);
          @(posedge clk); #1;
        end
      end
    end
    m_r_rvalid_i = 0; i_r_rready_i = 0;
    @(negedge clk);
    checkOutput("ionly_idle_after", {m_ar_arvalid_o, m_r_rready_o}, 2'b01);
    checkOutput("ionly_beat_count", 64'(iBeats), 64'd4);
    @(posedge clk); #1;
    i_r_rready_i = 1;
    @(negedge clk);
    captureHandshakes();

    // Three consecutive tie pairs alternate D, I, D, I, D, I
    grantLog.delete();
    repeat (3) begin
      stepCycle(100, 100, 100, 100);
      drainIdle();
    end
    checkOutput("tie_pairs_count", 64'(grantLog.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      got = (i < grantLog.size()) ? grantLog[i] : 4'hF;
      checkOutput($sformatf("tie_pair_order%0d", i), got, (i % 2 == 0) ? 4'd1 : 4'd0);
    end

    // Memory holds ARREADY low for five cycles while I also waits
    @(posedge clk); #1;
    d_ar_arvalid_i = 1; d_ar_araddr_i = 32'hABCD_0040; d_ar_arlen_i = 5'd2; m_ar_arready_i = 0;
    @(posedge clk); #1;
    i_ar_arvalid_i = 1; i_ar_araddr_i = 32'h500; i_ar_arlen_i = 5'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_ar", {m_ar_arvalid_o, d_ar_arready_o, i_ar_arready_o, m_ar_araddr_o},
                  {3'b100, 32'hABCD_0040});
      if (c < 4) begin @(posedge clk); #1; end
    end
    captureHandshakes();
    drainIdle();

    // Reset after beat 2 of 4: remaining beats are drained, not forwarded
    @(posedge clk); #1;
    i_ar_arvalid_i = 1; i_ar_araddr_i = 32'h400; i_ar_arlen_i = 5'd4; m_ar_arready_i = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstmid_ar", i_ar_arready_o, 1'b1);
    @(posedge clk); #1;
    i_ar_arvalid_i = 0; m_ar_arready_i = 0; m_r_rid_i = I_CACHE_ARID; i_r_rready_i = 1;
    for (int b = 0; b < 2; b++) begin
      m_r_rvalid_i = 1; m_r_rdata_i = 32'hBEEF_0000 + 32'(b);
      @(negedge clk);
      checkOutput("rstmid_beat", i_r_rvalid_o, 1'b1);
      @(posedge clk); #1;
    end
    m_r_rvalid_i = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; i_r_rready_i = 0;
    for (int b = 2; b < 4; b++) begin
      m_r_rvalid_i = 1; m_r_rdata_i = 32'hBEEF_0000 + 32'(b);
      @(negedge clk);
      checkOutput("rstmid_stray", {m_ar_arvalid_o, i_ar_arready_o, d_ar_arready_o,
                                   i_r_rvalid_o, d_r_rvalid_o, m_r_rready_o}, 6'b000001);
      @(posedge clk); #1;
    end
    m_r_rvalid_i = 0; i_r_rready_i = 1;
    @(negedge clk);
    captureHandshakes();

    // Randomized traffic from both caches against a jittery memory
    for (int n = 0; n < 3000; n++) stepCycle(25, 60, 70, 75);
    drainIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
